// File: rtl/ring_buffer_readout_if.sv
// Read-address handshake between the ring buffer readout controller and the RAM read path.
interface ring_buffer_readout_if #(
  parameter int unsigned ADDR_W = 29
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;

  modport master (output rd_addr, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_addr, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/ring_buffer_readout.sv
// LTscope capture ring buffer read-side controller: gates the writer until the ring is
// full, counts post-trigger samples, then replays every location oldest-first.
module ring_buffer_readout #(
  parameter int unsigned ADDR_W = 29
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arm,
  input  logic              trig,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] depth,
  input  logic [ADDR_W-1:0] post_cnt,
  output logic              capture_en,
  output logic              busy,
  output logic              done,
  ring_buffer_readout_if.master rd
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_STOP,
    S_READ,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_left;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] last_addr;

  logic [ADDR_W-1:0] depth_m1;
  logic [ADDR_W-1:0] pre;
  logic [ADDR_W-1:0] fill_inc;
  logic [ADDR_W-1:0] rd_cnt_inc;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [ADDR_W-1:0] start_addr;

  always_comb begin
    depth_m1    = depth - ONE;
    pre         = depth_m1 - post_cnt;
    fill_inc    = fill_cnt + ONE;
    rd_cnt_inc  = rd_cnt + ONE;
    rd_addr_nxt = (rd.rd_addr == depth_m1) ? '0 : rd.rd_addr + ONE;
    start_addr  = (last_addr == depth_m1) ? '0 : last_addr + ONE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      capture_en  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd.rd_addr  <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
      fill_cnt    <= '0;
      post_left   <= '0;
      rd_cnt      <= '0;
      last_addr   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (arm) begin
            fill_cnt   <= '0;
            capture_en <= 1'b1;
            busy       <= 1'b1;
            state      <= S_FILL;
          end
        end

        S_FILL: begin
          if (wr_en) begin
            fill_cnt  <= fill_inc;
            last_addr <= wr_addr;
          end
          // Leave on the write that reaches pre, or at once when pre is zero.
          if ((fill_cnt == pre) || (wr_en && (fill_inc == pre))) begin
            state <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (wr_en) begin
            last_addr <= wr_addr;
            if (trig) begin
              if (post_cnt == '0) begin
                capture_en <= 1'b0;
                state      <= S_STOP;
              end else begin
                post_left <= post_cnt;
                state     <= S_POST;
              end
            end
          end
        end

        S_POST: begin
          if (wr_en) begin
            last_addr <= wr_addr;
            post_left <= post_left - ONE;
            if (post_left == ONE) begin
              capture_en <= 1'b0;
              state      <= S_STOP;
            end
          end
        end

        S_STOP: begin
          rd.rd_addr  <= start_addr;
          rd.rd_valid <= 1'b1;
          rd.rd_last  <= 1'b0;
          rd_cnt      <= '0;
          state       <= S_READ;
        end

        S_READ: begin
          if (rd.rd_ready) begin
            if (rd.rd_last) begin
              rd.rd_valid <= 1'b0;
              rd.rd_last  <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              rd.rd_addr <= rd_addr_nxt;
              rd_cnt     <= rd_cnt_inc;
              rd.rd_last <= (rd_cnt_inc == depth_m1);
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_buffer_readout.sv
// Directed bench for ring_buffer_readout: capture, trigger, post-count and oldest-first readout.
module tb_ring_buffer_readout;

  localparam int unsigned AW = 29;

  logic          clk = 1'b0;
  logic          rstn;
  logic          arm;
  logic          trig;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] depth;
  logic [AW-1:0] post_cnt;
  logic          capture_en;
  logic          busy;
  logic          done;

  ring_buffer_readout_if #(.ADDR_W(AW)) rif ();

  ring_buffer_readout #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .arm        (arm),
    .trig       (trig),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .depth      (depth),
    .post_cnt   (post_cnt),
    .capture_en (capture_en),
    .busy       (busy),
    .done       (done),
    .rd         (rif)
  );

  always #5 clk = ~clk;

  int            passed = 0;
  int            total  = 0;
  logic [AW-1:0] wptr;

  // Writer model: address advances on every write, wrapping at the ring depth.
  task automatic tick();
    @(posedge clk);
    if (wr_en) wptr = (wptr == depth - 1'b1) ? '0 : wptr + 1'b1;
    @(negedge clk);
  endtask

  task automatic do_capture(input logic [AW-1:0] d, input logic [AW-1:0] p,
                            input logic [AW-1:0] start_wptr, input logic [AW-1:0] trig_at,
                            input int max_writes, output int n_wr,
                            output logic [AW-1:0] last_wr, output bit to);
    bit trig_done;
    bit stopped;
    depth = d; post_cnt = p; wptr = start_wptr;
    n_wr = 0; last_wr = '0; to = 1'b0; trig_done = 1'b0; stopped = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 3 * int'(d) + 10; c++) begin
      if (!capture_en || (max_writes > 0 && n_wr >= max_writes)) begin
        stopped = 1'b1;
        break;
      end
      wr_en   = 1'b1;
      wr_addr = wptr;
      trig    = (wptr == trig_at) && !trig_done;
      if (trig) trig_done = 1'b1;
      n_wr++;
      last_wr = wptr;
      tick();
    end
    wr_en = 1'b0;
    trig  = 1'b0;
    to    = !stopped;
  endtask

  task automatic run_read(input int mode, input logic [AW-1:0] start,
                          output int n_hs, output int n_err, output int n_last,
                          output int n_done, output logic [AW-1:0] last_hs);
    logic [15:0]   rpat;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] paddr;
    logic          plast;
    logic          rdy;
    bit            pstall;
    int            k;
    rpat = 16'b1011_0010_0111_0100;
    n_hs = 0; n_err = 0; n_last = 0; n_done = 0; last_hs = '0;
    exp_addr = start; k = 0; pstall = 1'b0; paddr = '0; plast = 1'b0;
    for (int c = 0; c < 4 * int'(depth) + 20; c++) begin
      rdy = (mode == 0) ? 1'b1 : rpat[c % 16];
      rif.rd_ready = rdy;
      if (pstall && (rif.rd_addr !== paddr || rif.rd_last !== plast)) n_err++;
      if (k < int'(depth) && rif.rd_valid !== 1'b1) n_err++;
      if (k >= int'(depth) && rif.rd_valid !== 1'b0) n_err++;
      if (done) begin
        n_done++;
        break;
      end
      if (rif.rd_valid) begin
        if (rif.rd_addr !== exp_addr) n_err++;
        if (rif.rd_last !== (k == int'(depth) - 1)) n_err++;
        if (rdy) begin
          n_hs++;
          if (rif.rd_last) begin
            n_last++;
            last_hs = rif.rd_addr;
          end
          k++;
          exp_addr = (exp_addr == depth - 1'b1) ? '0 : exp_addr + 1'b1;
        end
      end
      pstall = rif.rd_valid && !rdy;
      paddr  = rif.rd_addr;
      plast  = rif.rd_last;
      tick();
    end
    rif.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    total++; if (capture_en !== 1'b0) $display("FAIL rst_capture_en: got %0b want 0", capture_en); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else passed++;
    total++; if (rif.rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %0b want 0", rif.rd_valid); else passed++;
    total++; if (rif.rd_last !== 1'b0) $display("FAIL rst_rd_last: got %0b want 0", rif.rd_last); else passed++;
    total++; if (rif.rd_addr !== '0) $display("FAIL rst_rd_addr: got %0d want 0", rif.rd_addr); else passed++;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n_wr, n_hs, n_err, n_last, n_done;
    logic [AW-1:0] last_wr, last_hs;
    bit to;
    do_capture(29'd8, 29'd3, 29'd0, 29'd5, 0, n_wr, last_wr, to);
    total++; if (to !== 1'b0) $display("FAIL basic_capture_timeout: got %0b want 0", to); else passed++;
    total++; if (n_wr !== 9) $display("FAIL basic_writes: got %0d want 9", n_wr); else passed++;
    total++; if (last_wr !== 29'd0) $display("FAIL basic_last_write: got %0d want 0", last_wr); else passed++;
    total++; if (rif.rd_valid !== 1'b0) $display("FAIL basic_stop_valid: got %0b want 0", rif.rd_valid); else passed++;
    tick();
    total++; if (rif.rd_valid !== 1'b1) $display("FAIL basic_read_valid: got %0b want 1", rif.rd_valid); else passed++;
    total++; if (rif.rd_addr !== 29'd1) $display("FAIL basic_start_addr: got %0d want 1", rif.rd_addr); else passed++;
    total++; if (capture_en !== 1'b0) $display("FAIL basic_read_capture_en: got %0b want 0", capture_en); else passed++;
    run_read(0, 29'd1, n_hs, n_err, n_last, n_done, last_hs);
    total++; if (n_hs !== 8) $display("FAIL basic_handshakes: got %0d want 8", n_hs); else passed++;
    total++; if (n_err !== 0) $display("FAIL basic_read_errors: got %0d want 0", n_err); else passed++;
    total++; if (n_last !== 1 || last_hs !== 29'd0) $display("FAIL basic_rd_last: got %0d at %0d want 1 at 0", n_last, last_hs); else passed++;
    total++; if (n_done !== 1 || busy !== 1'b1) $display("FAIL basic_done: got done=%0d busy=%0b want 1 1", n_done, busy); else passed++;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle: got done=%0b busy=%0b want 0 0", done, busy); else passed++;
  endtask

  task automatic test_deep_post0();
    int n_wr, n_hs, n_err, n_last, n_done;
    logic [AW-1:0] last_wr, last_hs;
    bit to;
    do_capture(29'd16400, 29'd0, 29'd0, 29'd16399, 0, n_wr, last_wr, to);
    total++; if (to !== 1'b0) $display("FAIL post0_timeout: got %0b want 0", to); else passed++;
    total++; if (n_wr !== 16400) $display("FAIL post0_writes: got %0d want 16400", n_wr); else passed++;
    total++; if (last_wr !== 29'd16399) $display("FAIL post0_last_write: got %0d want 16399", last_wr); else passed++;
    tick();
    total++; if (rif.rd_addr !== 29'd0 || rif.rd_valid !== 1'b1) $display("FAIL post0_start: got %0d v=%0b want 0 v=1", rif.rd_addr, rif.rd_valid); else passed++;
    run_read(0, 29'd0, n_hs, n_err, n_last, n_done, last_hs);
    total++; if (n_hs !== 16400) $display("FAIL post0_handshakes: got %0d want 16400", n_hs); else passed++;
    total++; if (n_err !== 0) $display("FAIL post0_read_errors: got %0d want 0", n_err); else passed++;
    total++; if (n_last !== 1 || last_hs !== 29'd16399) $display("FAIL post0_rd_last: got %0d at %0d want 1 at 16399", n_last, last_hs); else passed++;
    total++; if (n_done !== 1) $display("FAIL post0_done: got %0d want 1", n_done); else passed++;
    tick();
  endtask

  task automatic test_deep_pre0();
    int n_wr, n_hs, n_err, n_last, n_done;
    logic [AW-1:0] last_wr, last_hs;
    bit to;
    do_capture(29'd16400, 29'd16399, 29'd99, 29'd100, 0, n_wr, last_wr, to);
    total++; if (to !== 1'b0) $display("FAIL pre0_timeout: got %0b want 0", to); else passed++;
    total++; if (n_wr !== 16401) $display("FAIL pre0_writes: got %0d want 16401", n_wr); else passed++;
    total++; if (last_wr !== 29'd99) $display("FAIL pre0_last_write: got %0d want 99", last_wr); else passed++;
    tick();
    total++; if (rif.rd_addr !== 29'd100) $display("FAIL pre0_start: got %0d want 100", rif.rd_addr); else passed++;
    run_read(0, 29'd100, n_hs, n_err, n_last, n_done, last_hs);
    total++; if (n_hs !== 16400) $display("FAIL pre0_handshakes: got %0d want 16400", n_hs); else passed++;
    total++; if (n_err !== 0) $display("FAIL pre0_read_errors: got %0d want 0", n_err); else passed++;
    total++; if (n_last !== 1 || last_hs !== 29'd99) $display("FAIL pre0_rd_last: got %0d at %0d want 1 at 99", n_last, last_hs); else passed++;
    total++; if (n_done !== 1) $display("FAIL pre0_done: got %0d want 1", n_done); else passed++;
    tick();
  endtask

  task automatic test_stall();
    int n_wr, n_hs, n_err, n_last, n_done;
    logic [AW-1:0] last_wr, last_hs;
    bit to;
    do_capture(29'd8, 29'd3, 29'd0, 29'd5, 0, n_wr, last_wr, to);
    total++; if (n_wr !== 9 || last_wr !== 29'd0) $display("FAIL stall_capture: got %0d writes last %0d want 9 last 0", n_wr, last_wr); else passed++;
    tick();
    arm = 1'b1;
    run_read(1, 29'd1, n_hs, n_err, n_last, n_done, last_hs);
    arm = 1'b0;
    total++; if (n_hs !== 8) $display("FAIL stall_handshakes: got %0d want 8", n_hs); else passed++;
    total++; if (n_err !== 0) $display("FAIL stall_read_errors: got %0d want 0", n_err); else passed++;
    total++; if (n_last !== 1 || last_hs !== 29'd0) $display("FAIL stall_rd_last: got %0d at %0d want 1 at 0", n_last, last_hs); else passed++;
    total++; if (n_done !== 1) $display("FAIL stall_done: got %0d want 1", n_done); else passed++;
    tick();
    total++; if (busy !== 1'b0 || capture_en !== 1'b0) $display("FAIL stall_arm_ignored: got busy=%0b cap=%0b want 0 0", busy, capture_en); else passed++;
  endtask

  task automatic test_trig_ignored();
    logic [11:0] we_tab;
    logic [11:0] tr_tab;
    int cap_bad, n_hs, n_err, n_last, n_done;
    logic [AW-1:0] last_hs;
    we_tab = 12'b1101_1010_1111;
    tr_tab = 12'b0101_1101_1101;
    depth = 29'd8; post_cnt = 29'd3; wptr = '0; cap_bad = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (capture_en !== 1'b1) cap_bad++;
      wr_en   = we_tab[i] & capture_en;
      wr_addr = wptr;
      trig    = tr_tab[i];
      tick();
    end
    wr_en = 1'b0;
    trig  = 1'b0;
    total++; if (cap_bad !== 0) $display("FAIL ign_capture_held: got %0d drops want 0", cap_bad); else passed++;
    total++; if (capture_en !== 1'b0) $display("FAIL ign_capture_stop: got %0b want 0", capture_en); else passed++;
    tick();
    total++; if (rif.rd_addr !== 29'd1) $display("FAIL ign_start: got %0d want 1", rif.rd_addr); else passed++;
    run_read(0, 29'd1, n_hs, n_err, n_last, n_done, last_hs);
    total++; if (n_hs !== 8 || n_err !== 0) $display("FAIL ign_read: got %0d hs %0d err want 8 hs 0 err", n_hs, n_err); else passed++;
    total++; if (n_done !== 1 || last_hs !== 29'd0) $display("FAIL ign_done: got %0d last %0d want 1 last 0", n_done, last_hs); else passed++;
    tick();
  endtask

  task automatic test_reset_abort();
    int n_wr, n_hs, n_err, n_last, n_done, bad;
    logic [AW-1:0] last_wr, last_hs;
    bit to;
    do_capture(29'd8, 29'd3, 29'd0, 29'd5, 7, n_wr, last_wr, to);
    total++; if (capture_en !== 1'b1 || last_wr !== 29'd6) $display("FAIL abort_post_reached: got cap=%0b last %0d want 1 last 6", capture_en, last_wr); else passed++;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    total++; if ({capture_en, busy, done, rif.rd_valid, rif.rd_last} !== 5'b0 || rif.rd_addr !== '0)
      $display("FAIL abort_post_outputs: got %b addr %0d want 00000 addr 0", {capture_en, busy, done, rif.rd_valid, rif.rd_last}, rif.rd_addr); else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy || capture_en || rif.rd_valid) bad++;
    end
    total++; if (bad !== 0) $display("FAIL abort_post_idle: got %0d active cycles want 0", bad); else passed++;

    do_capture(29'd8, 29'd3, 29'd0, 29'd5, 0, n_wr, last_wr, to);
    tick();
    rif.rd_ready = 1'b1;
    tick();
    tick();
    tick();
    rif.rd_ready = 1'b0;
    total++; if (rif.rd_addr !== 29'd4 || rif.rd_valid !== 1'b1) $display("FAIL abort_read_reached: got %0d v=%0b want 4 v=1", rif.rd_addr, rif.rd_valid); else passed++;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    total++; if ({capture_en, busy, done, rif.rd_valid, rif.rd_last} !== 5'b0 || rif.rd_addr !== '0)
      $display("FAIL abort_read_outputs: got %b addr %0d want 00000 addr 0", {capture_en, busy, done, rif.rd_valid, rif.rd_last}, rif.rd_addr); else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy || rif.rd_valid) bad++;
    end
    total++; if (bad !== 0) $display("FAIL abort_read_idle: got %0d active cycles want 0", bad); else passed++;

    do_capture(29'd8, 29'd3, 29'd0, 29'd5, 0, n_wr, last_wr, to);
    total++; if (n_wr !== 9 || to !== 1'b0) $display("FAIL recover_capture: got %0d writes to=%0b want 9 to=0", n_wr, to); else passed++;
    tick();
    run_read(0, 29'd1, n_hs, n_err, n_last, n_done, last_hs);
    total++; if (n_hs !== 8 || n_err !== 0 || n_done !== 1) $display("FAIL recover_read: got %0d hs %0d err %0d done want 8 0 1", n_hs, n_err, n_done); else passed++;
    tick();
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; trig = 1'b0; wr_en = 1'b0; wr_addr = '0;
    depth = 29'd8; post_cnt = 29'd3; wptr = '0; rif.rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_trig_ignored();
    test_reset_abort();
    test_deep_post0();
    test_deep_pre0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ring_buffer_readout.md
Name: ring_buffer_readout

Overview:
- Read-side controller for the LTscope capture ring buffer.
- Arms a capture and gates the write-address generator's enable (capture_en), so the ring is guaranteed full before a trigger is accepted.
- After the trigger, counts the programmed post-trigger samples, then freezes the writer.
- Then emits every RAM read address oldest-first under a valid/ready handshake, wrapping at the runtime depth.

Parameters:
- ADDR_W, 29, width of all address/depth/count signals.

Ports:
- clk       in   1       system clock, all logic on rising edge
- rstn      in   1       reset, synchronous, active-low
- arm       in   1       start new capture (honoured only in IDLE)
- trig      in   1       trigger qualifier, level-sampled
- wr_en     in   1       writer's enable this cycle (a sample is written at wr_addr)
- wr_addr   in   ADDR_W  writer's address written this cycle
- depth     in   ADDR_W  ring depth, legal 2..2^ADDR_W-1, static while busy
- post_cnt  in   ADDR_W  samples stored after trigger sample, legal 0..depth-1, static while busy
- rd_ready  in   1       downstream accepts rd_addr
- capture_en out 1       writer enable gate (writer en = source_valid & capture_en)
- rd_addr   out  ADDR_W  RAM read address
- rd_valid  out  1       rd_addr valid
- rd_last   out  1       marks final (newest) address of readout
- busy      out  1       high in any state except IDLE
- done      out  1       one-cycle pulse after last read accepted

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE; all outputs 0; internal counters and last_addr 0. Reset mid-capture or mid-read aborts immediately; no done pulse.
- States: IDLE, FILL, ARMED, POST, STOP, READ, DONE. All outputs are registered.
- IDLE: on arm, go FILL; clear fill_cnt; capture_en=1 from the next cycle.
- FILL:
  - Each wr_en increments fill_cnt and loads last_addr<=wr_addr.
  - When fill_cnt reaches pre = depth-1-post_cnt, go ARMED. If pre=0, go ARMED the cycle after entering FILL.
  - trig is ignored in FILL.
- ARMED:
  - Each wr_en loads last_addr.
  - trig&&wr_en marks that sample as the trigger sample; trig without wr_en is ignored.
  - On trigger: if post_cnt=0, go STOP; else load post counter=post_cnt and go POST.
- POST:
  - Each wr_en loads last_addr and decrements the counter.
  - On the wr_en that takes the counter to 0, go STOP.
  - trig is ignored.
- STOP:
  - capture_en=0; the writer must not write from this cycle.
  - Compute start = (last_addr==depth-1) ? 0 : last_addr+1. Load read counter=0. Go READ.
- READ:
  - rd_valid=1, rd_addr=start initially.
  - On rd_valid&&rd_ready: rd_addr advances by 1, wrapping depth-1→0, and the counter increments.
  - rd_addr and rd_last hold while rd_ready=0.
  - rd_last=1 exactly when counter=depth-1; that address equals last_addr.
  - When the last address is accepted: rd_valid=0, go DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- capture_en=1 exactly in FILL, ARMED and POST.
- Exactly depth addresses are issued per capture, each ring location once, oldest first.
- arm while busy is ignored. depth/post_cnt are sampled combinationally and must not change while busy.
- Wrap arithmetic is a compare-with-depth-1, not a modulo; addresses never reach ≥depth.
- Latency: trigger-qualifying (or last post) write edge → STOP next cycle → rd_valid asserted the cycle after.

Test Plan:
- depth=8, post_cnt=3, writer counts 0,1,2… from addr 0, trig with write at addr 5 → ARMED after the 4th write (addr 3); post writes at 6,7,0; capture_en falls the cycle after the write at addr 0; rd_addr sequence 1,2,3,4,5,6,7,0; rd_last on 0; done pulse once.
- depth=16400, post_cnt=0, trig coincident with write at addr 16399 → start=0; 16400 addresses issued 0..16399; rd_last on 16399; no extra writer enable after the trigger cycle.
- depth=16400, post_cnt=16399 (pre=0), trig on the first write in ARMED at addr 100 → ARMED one cycle after arm; STOP after the write at addr 99 (wrapped); readout 100..16399,0..99.
- rd_ready toggled pseudo-randomly during READ (depth=8) → rd_addr/rd_last stable while stalled; sequence identical to the first scenario; exactly 8 handshakes.
- trig pulses during FILL and POST, and trig with wr_en=0 in ARMED → all ignored; the capture completes only on the first trig&&wr_en in ARMED.
- rstn=0 for one cycle mid-POST and again mid-READ → next cycle IDLE, all outputs 0, no done; a subsequent arm completes normally.
